mem_access_ctrl: RTL and testbench
==================================

// Module: mem_access_ctrl
// PURPOSE
//   Initiator side of the single-port word memory interface (addr/Din/we/re/out).
//   Accepts load/store requests from the core over a valid/ready channel.
//   Converts each byte address to a word index and bounds/alignment-checks it.
//   Drives exactly one memory read and/or write per request; returns data/status on a valid/ready response channel.
// PARAMETERS
//   ADDR_W     32   request byte-address width; mem_addr width
//   DATA_W     32   data width (word = 4 bytes)
//   MEM_WORDS  256  number of words in the attached memory
// PORTS
//   clk        in   1       rising-edge clock
//   rst_n      in   1       asynchronous, active-low reset
//   req_valid  in   1       request present
//   req_ready  out  1       controller can accept a request
//   req_we     in   1       1 = store, 0 = load
//   req_addr   in   ADDR_W  byte address
//   req_wdata  in   DATA_W  store data (low bytes for subword)
//   req_size   in   2       00 byte, 01 half, 10 word, 11 illegal (SUBWORD_EN only)
//   rsp_valid  out  1       response present
//   rsp_ready  in   1       core accepts response
//   rsp_rdata  out  DATA_W  load data; 0 for stores and errors
//   rsp_err    out  1       request rejected; no memory access made
//   mem_addr   out  ADDR_W  word index to memory
//   mem_din    out  DATA_W  write data to memory
//   mem_we     out  1       memory write enable (written on clk rise)
//   mem_re     out  1       memory read enable
//   mem_dout   in   DATA_W  memory read data, combinational from mem_addr
// BEHAVIOUR
//   - FSM states: IDLE, RD, WR, RESP. Moore outputs decoded from registered state.
//   - Reset: state=IDLE; req_ready=1; rsp_valid=0; rsp_rdata=0; rsp_err=0.
//     Reset also forces mem_addr=0, mem_din=0, mem_we=0, mem_re=0.
//     All of these take effect immediately on rst_n low.
//   - IDLE: req_ready=1. req_valid&req_ready captures we/addr/wdata/size.
//     idx = req_addr[ADDR_W-1:2].
//   - err condition: idx >= MEM_WORDS, or misaligned access.
//     Misaligned: addr[1:0]!=0 for word, addr[0]!=0 for half, or size=11.
//   - IDLE transitions: err -> RESP (err=1, rdata=0); load -> RD; word store -> WR;
//     subword store -> RD.
//   - RD: one cycle. mem_re=1, mem_addr=idx. mem_dout is registered at the end of the cycle.
//     Load -> RESP. Subword store -> WR with the merged word.
//   - WR: one cycle. mem_we=1, mem_addr=idx, mem_din=store word -> RESP.
//   - RESP: rsp_valid=1 and rsp_rdata/rsp_err held stable until rsp_ready -> IDLE.
//   - Only IDLE has req_ready=1; requests arriving in other states are not accepted.
//   - Outside RD/WR: mem_re=0, mem_we=0, mem_addr=0, mem_din=0.
//   - Latency, counted from accept edge N: load rsp_valid at N+2; word store N+2;
//     subword store N+3; error N+1. rsp_ready high on arrival -> IDLE at next edge.
//   - Reset during WR: mem_we drops before the next clk edge, so no write occurs.
//     The pending request is discarded.
// CONFIGURATION
//   MEM_SUBWORD_EN defined:
//     req_size honoured. Loads extract the addressed byte/half lane and zero-extend it.
//     Subword stores do a read-modify-write (RD then WR), replacing only the addressed lane.
//   MEM_SUBWORD_EN undefined:
//     req_size ignored; every access is a word access.
//     addr[1:0]!=0 -> err. Stores go IDLE->WR directly; there is no merge logic.
// TESTING
//   1. Word store 0x10/0xDEADBEEF -> one-cycle mem_we pulse, mem_addr=4, mem_din=0xDEADBEEF;
//      rsp_valid at N+2, err=0, rdata=0.
//   2. Word load 0x10 after test 1 -> one-cycle mem_re, mem_addr=4; rsp_rdata=0xDEADBEEF at N+2.
//   3. Load 0x400 (idx 256); word load 0x11 with MEM_SUBWORD_EN undefined
//      -> no mem_re/mem_we; rsp_err=1, rdata=0 at N+1.
//   4. rsp_ready low 5 cycles with req_valid held high -> rsp_valid/rdata stable, req_ready=0,
//      second request accepted only after the handshake.
//   5. rst_n low during WR of store 0x20/0x12345678 -> mem_we=0 immediately;
//      later load 0x20 returns prior value; req_ready=1 after release.
//   6. MEM_SUBWORD_EN: byte store 0xAB to 0x11 over 0xDEADBEEF -> RD then WR, mem_din=0xDEADABEF,
//      rsp at N+3. Byte load 0x13 -> 0x000000DE.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// ============================================================================
// mem_access_ctrl
//
// Initiator side of a single-port word memory (addr/din/we/re/dout).
// The core issues load/store requests over a valid/ready channel. Each byte
// address is turned into a word index and checked for range and alignment.
// Each request then makes exactly one memory read and/or one memory write.
// Data and status return to the core over a valid/ready response channel.
//
// Optional feature, selected by the macro MEM_SUBWORD_EN:
//   defined   : req_size is honoured.
//               Byte and half loads extract the addressed lane and zero-extend it.
//               Byte and half stores do a read-modify-write (RD, then WR).
//   undefined : every access is a word access, and req_size is ignored.
//               Any addr[1:0] != 0 is an error.
//               Stores go straight from IDLE to WR.
//
// Ports
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   req_valid/ready   request handshake
//   req_we            1 = store, 0 = load
//   req_addr          byte address
//   req_wdata         store data (low bytes used for subword stores)
//   req_size          00 byte, 01 half, 10 word, 11 illegal
//   rsp_valid/ready   response handshake
//   rsp_rdata         load data; 0 for stores and errors
//   rsp_err           request rejected, no memory access made
//   mem_addr          word index to the memory
//   mem_din           write data to the memory
//   mem_we / mem_re   memory write / read enables
//   mem_dout          memory read data, combinational from mem_addr
// ============================================================================
module mem_access_ctrl #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_WORDS = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [1:0]        req_size,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_dout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-3:0]   idx_q, idx_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;

    // Every output is a flop. Its next value is decoded from the next state,
    // so it changes on the same edge as the state register.
    logic                req_ready_q, req_ready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_din_q, mem_din_d;
    logic                mem_we_q, mem_we_d;
    logic                mem_re_q, mem_re_d;

    logic [ADDR_W-3:0]   req_idx;
    logic                misalign;
    logic                req_err;
    logic                req_subword;
    logic [DATA_W-1:0]   load_data;

`ifdef MEM_SUBWORD_EN
    logic                we_q, we_d;
    logic [1:0]          size_q, size_d;
    logic [1:0]          lane_q, lane_d;
    logic [DATA_W-1:0]   shifted;
    logic [DATA_W-1:0]   mask;
    logic [DATA_W-1:0]   merged;
`else
    // In word-only mode the size field is not needed.
    logic                unused_size;
    assign unused_size = ^req_size;
`endif

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        wdata_d     = wdata_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        req_idx     = req_addr[ADDR_W-1:2];

`ifdef MEM_SUBWORD_EN
        we_d   = we_q;
        size_d = size_q;
        lane_d = lane_q;
        unique case (req_size)
            2'b00:   misalign = 1'b0;
            2'b01:   misalign = req_addr[0];
            2'b10:   misalign = (req_addr[1:0] != 2'b00);
            default: misalign = 1'b1;
        endcase
        req_subword = (req_size != 2'b10);

        // Lane shift. A half access is aligned, so lane_q[0] is 0 and the same
        // byte-granular shift selects the correct half.
        shifted = mem_dout >> {lane_q, 3'b000};
        unique case (size_q)
            2'b00:   load_data = DATA_W'(shifted[7:0]);
            2'b01:   load_data = DATA_W'(shifted[15:0]);
            default: load_data = mem_dout;
        endcase
        mask   = (size_q == 2'b00) ? DATA_W'(8'hFF) : DATA_W'(16'hFFFF);
        mask   = mask << {lane_q, 3'b000};
        merged = (mem_dout & ~mask) | ((wdata_q << {lane_q, 3'b000}) & mask);
`else
        misalign    = (req_addr[1:0] != 2'b00);
        req_subword = 1'b0;
        load_data   = mem_dout;
`endif

        req_err = ({2'b00, req_idx} >= ADDR_W'(MEM_WORDS)) || misalign;

        unique case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    idx_d       = req_idx;
                    wdata_d     = req_wdata;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b0;
`ifdef MEM_SUBWORD_EN
                    we_d   = req_we;
                    size_d = req_size;
                    lane_d = req_addr[1:0];
`endif
                    if (req_err) begin
                        state_d   = RESP;
                        rsp_err_d = 1'b1;
                    end else if (!req_we || req_subword) begin
                        // Loads read the word. Subword stores also read it,
                        // to merge the new lane into the existing word.
                        state_d = RD;
                    end else begin
                        state_d = WR;
                    end
                end
            end
            RD: begin
`ifdef MEM_SUBWORD_EN
                if (we_q) begin
                    wdata_d = merged;
                    state_d = WR;
                end else begin
                    rsp_rdata_d = load_data;
                    state_d     = RESP;
                end
`else
                rsp_rdata_d = load_data;
                state_d     = RESP;
`endif
            end
            WR: begin
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        req_ready_d = (state_d == IDLE);
        rsp_valid_d = (state_d == RESP);
        mem_re_d    = (state_d == RD);
        mem_we_d    = (state_d == WR);
        mem_addr_d  = (state_d == RD || state_d == WR) ? {2'b00, idx_d} : '0;
        mem_din_d   = (state_d == WR) ? wdata_d : '0;
    end

    // The reset is asynchronous, so the enables drop as soon as rst_n falls.
    // A write that is in progress in WR is therefore abandoned before it can
    // happen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            wdata_q     <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_din_q   <= '0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
`ifdef MEM_SUBWORD_EN
            we_q        <= 1'b0;
            size_q      <= 2'b10;
            lane_q      <= 2'b00;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            wdata_q     <= wdata_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            mem_addr_q  <= mem_addr_d;
            mem_din_q   <= mem_din_d;
            mem_we_q    <= mem_we_d;
            mem_re_q    <= mem_re_d;
`ifdef MEM_SUBWORD_EN
            we_q        <= we_d;
            size_q      <= size_d;
            lane_q      <= lane_d;
`endif
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign mem_addr  = mem_addr_q;
    assign mem_din   = mem_din_q;
    assign mem_we    = mem_we_q;
    assign mem_re    = mem_re_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// ============================================================================
// tb_mem_access_ctrl
//
// Directed testbench for mem_access_ctrl with the default parameters.
// It models the attached word memory: the write happens on the clock rise and
// the read is combinational.
// The subword cases run only when MEM_SUBWORD_EN is defined.
// ============================================================================
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic        mem_we;
    logic        mem_re;
    logic [31:0] mem_dout;

    always #5 clk = ~clk;

    mem_access_ctrl #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .MEM_WORDS (256)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_size  (req_size),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_dout  (mem_dout)
    );

    // Memory model. While preload is high, word i is filled with 0xC0DE0000 + i.
    logic [31:0] mem [256];
    logic        preload;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'hC0DE0000 + i;
        end else if (mem_we) begin
            mem[mem_addr[7:0]] <= mem_din;
        end
    end
    assign mem_dout = mem[mem_addr[7:0]];

    // Count the memory access pulses, sampled away from the active clock edge.
    int          re_cnt = 0;
    int          we_cnt = 0;
    logic [31:0] re_addr = '0;
    logic [31:0] we_addr = '0;
    logic [31:0] we_din  = '0;

    always @(negedge clk) begin
        if (mem_re) begin
            re_cnt++;
            re_addr = mem_addr;
        end
        if (mem_we) begin
            we_cnt++;
            we_addr = mem_addr;
            we_din  = mem_din;
        end
    end

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request with rsp_ready held high.
    // lat is the number of edges from the accept edge to the first edge at
    // which rsp_valid is high.
    task automatic do_req(input string name, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [1:0] size,
                          output logic [31:0] rdata, output logic err, output int lat);
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_size  = size;
        rsp_ready = 1'b1;
        check_eq({name, "_req_ready"}, 32'(req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        rdata = rsp_rdata;
        err   = rsp_err;
        check_eq({name, "_rsp_mem_we"},   32'(mem_we), 32'd0);
        check_eq({name, "_rsp_mem_re"},   32'(mem_re), 32'd0);
        check_eq({name, "_rsp_mem_addr"}, mem_addr,    32'd0);
        $display("txn %-10s we=%0d addr=%h wdata=%h size=%b -> rdata=%h err=%0d lat=%0d",
                 name, we, addr, wdata, size, rdata, err, lat);
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;
    int          b_re;
    int          b_we;

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_size  = 2'b10;
        rsp_ready = 1'b1;
        preload   = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_req_ready", 32'(req_ready), 32'd1);
        check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_rsp_rdata", rsp_rdata, 32'd0);
        check_eq("rst_rsp_err",   32'(rsp_err), 32'd0);
        check_eq("rst_mem_we",    32'(mem_we), 32'd0);
        check_eq("rst_mem_re",    32'(mem_re), 32'd0);
        check_eq("rst_mem_addr",  mem_addr, 32'd0);
        check_eq("rst_mem_din",   mem_din, 32'd0);
        preload = 1'b0;
        rst_n   = 1'b1;

        // Word store 0x10 <- 0xDEADBEEF.
        b_re = re_cnt; b_we = we_cnt;
        do_req("st_w10", 1'b1, 32'h10, 32'hDEADBEEF, 2'b10, rd, er, lat);
        check_eq("st_w10_lat",   32'(lat), 32'd2);
        check_eq("st_w10_err",   32'(er), 32'd0);
        check_eq("st_w10_rdata", rd, 32'd0);
        check_eq("st_w10_we_n",  32'(we_cnt - b_we), 32'd1);
        check_eq("st_w10_re_n",  32'(re_cnt - b_re), 32'd0);
        check_eq("st_w10_addr",  we_addr, 32'd4);
        check_eq("st_w10_din",   we_din, 32'hDEADBEEF);

        // Word load 0x10.
        b_re = re_cnt; b_we = we_cnt;
        do_req("ld_w10", 1'b0, 32'h10, 32'h0, 2'b10, rd, er, lat);
        check_eq("ld_w10_lat",   32'(lat), 32'd2);
        check_eq("ld_w10_err",   32'(er), 32'd0);
        check_eq("ld_w10_rdata", rd, 32'hDEADBEEF);
        check_eq("ld_w10_re_n",  32'(re_cnt - b_re), 32'd1);
        check_eq("ld_w10_we_n",  32'(we_cnt - b_we), 32'd0);
        check_eq("ld_w10_addr",  re_addr, 32'd4);

        // Last valid word (idx 255).
        do_req("ld_w3fc", 1'b0, 32'h3FC, 32'h0, 2'b10, rd, er, lat);
        check_eq("ld_w3fc_lat",   32'(lat), 32'd2);
        check_eq("ld_w3fc_err",   32'(er), 32'd0);
        check_eq("ld_w3fc_rdata", rd, 32'hC0DE00FF);

        // Out of range (idx 256) and misaligned requests.
        b_re = re_cnt; b_we = we_cnt;
        do_req("ld_oor", 1'b0, 32'h400, 32'h0, 2'b10, rd, er, lat);
        check_eq("ld_oor_lat",   32'(lat), 32'd1);
        check_eq("ld_oor_err",   32'(er), 32'd1);
        check_eq("ld_oor_rdata", rd, 32'd0);
        do_req("ld_mis", 1'b0, 32'h11, 32'h0, 2'b10, rd, er, lat);
        check_eq("ld_mis_lat",   32'(lat), 32'd1);
        check_eq("ld_mis_err",   32'(er), 32'd1);
        check_eq("ld_mis_rdata", rd, 32'd0);
        do_req("st_oor", 1'b1, 32'h400, 32'h55AA55AA, 2'b10, rd, er, lat);
        check_eq("st_oor_err",   32'(er), 32'd1);
        check_eq("err_re_n",     32'(re_cnt - b_re), 32'd0);
        check_eq("err_we_n",     32'(we_cnt - b_we), 32'd0);

        // Response back-pressure with req_valid held high.
        b_re = re_cnt;
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'h10;
        req_size  = 2'b10;
        @(posedge clk);
        @(negedge clk);
        lat = 1;
        while (!rsp_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check_eq("bp_lat", 32'(lat), 32'd2);
        for (int i = 0; i < 5; i++) begin
            check_eq("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            check_eq("bp_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
            check_eq("bp_req_ready", 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        check_eq("bp_re_n_stall", 32'(re_cnt - b_re), 32'd1);
        $display("txn %-10s held rsp_ready low 5 cycles rdata=%h", "bp_first", rsp_rdata);
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("bp_idle_ready", 32'(req_ready), 32'd1);
        check_eq("bp_idle_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check_eq("bp2_lat",   32'(lat), 32'd2);
        check_eq("bp2_rdata", rsp_rdata, 32'hDEADBEEF);
        check_eq("bp2_re_n",  32'(re_cnt - b_re), 32'd2);
        $display("txn %-10s second request after handshake rdata=%h lat=%0d", "bp_second", rsp_rdata, lat);

        // Reset in the WR cycle of store 0x20 <- 0x12345678.
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h20;
        req_wdata = 32'h12345678;
        req_size  = 2'b10;
        @(posedge clk);
        #2;
        check_eq("rw_mem_we_pre", 32'(mem_we), 32'd1);
        rst_n     = 1'b0;
        req_valid = 1'b0;
        #1;
        check_eq("rw_mem_we",    32'(mem_we), 32'd0);
        check_eq("rw_mem_addr",  mem_addr, 32'd0);
        check_eq("rw_mem_din",   mem_din, 32'd0);
        check_eq("rw_req_ready", 32'(req_ready), 32'd1);
        check_eq("rw_rsp_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        $display("txn %-10s reset asserted during WR", "rst_wr");
        do_req("ld_w20", 1'b0, 32'h20, 32'h0, 2'b10, rd, er, lat);
        check_eq("ld_w20_rdata", rd, 32'hC0DE0008);
        check_eq("ld_w20_err",   32'(er), 32'd0);

`ifdef MEM_SUBWORD_EN
        // Byte store 0xAB at 0x11 over the word 0xDEADBEEF.
        b_re = re_cnt; b_we = we_cnt;
        do_req("st_b11", 1'b1, 32'h11, 32'h000000AB, 2'b00, rd, er, lat);
        check_eq("st_b11_lat",  32'(lat), 32'd3);
        check_eq("st_b11_err",  32'(er), 32'd0);
        check_eq("st_b11_re_n", 32'(re_cnt - b_re), 32'd1);
        check_eq("st_b11_we_n", 32'(we_cnt - b_we), 32'd1);
        check_eq("st_b11_din",  we_din, 32'hDEADABEF);
        do_req("ld_b13", 1'b0, 32'h13, 32'h0, 2'b00, rd, er, lat);
        check_eq("ld_b13_lat",   32'(lat), 32'd2);
        check_eq("ld_b13_rdata", rd, 32'h000000DE);
        do_req("ld_h12", 1'b0, 32'h12, 32'h0, 2'b01, rd, er, lat);
        check_eq("ld_h12_rdata", rd, 32'h0000DEAD);
        do_req("ld_h11", 1'b0, 32'h11, 32'h0, 2'b01, rd, er, lat);
        check_eq("ld_h11_err",   32'(er), 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
